// File: rtl/fft_pair_buffer.sv
// -----------------------------------------------------------------------------
// fft_pair_buffer
//   Radix-2 SDF pairing buffer for one FFT stage. The first half of each frame
//   is written into an internal RAM; each second-half sample is then emitted
//   together with the stored first-half sample at the same offset. The input
//   may have gaps (data_in_valid low). The last pair of each frame is flagged.
//   The half-frame length is chosen at run time up to 2^MAX_LOG2.
//
//   Optional feature (define FFT_PAIR_BUF_IDX_EN):
//     adds data_out_idx, the pair index within the frame. This is meant as
//     the twiddle ROM address for the downstream butterfly.
//
// Ports
//   clk             rising-edge clock
//   rst             synchronous active-high reset
//   half_len_log2   requested log2 of the half-frame length. It is clamped
//                   to 1..MAX_LOG2 and latched only at reset and at the
//                   frame wrap.
//   data_in         input sample {re, im}
//   data_in_valid   data_in is valid this cycle
//   data_out1       x1, the buffered first-half sample
//   data_out2       x2, the second-half sample paired with x1
//   data_out_valid  data_out1/data_out2 form a valid pair
//   data_out_last   last pair of the frame (only with data_out_valid)
//   data_out_idx    pair index 0..half_len-1 (FFT_PAIR_BUF_IDX_EN only)
// -----------------------------------------------------------------------------
module fft_pair_buffer #(
  parameter int DATA_W   = 64,
  parameter int MAX_LOG2 = 11,
  parameter int CFG_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CFG_W-1:0]  half_len_log2,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_in_valid,
  output logic [DATA_W-1:0] data_out1,
  output logic [DATA_W-1:0] data_out2,
  output logic              data_out_valid,
  output logic              data_out_last
`ifdef FFT_PAIR_BUF_IDX_EN
  ,
  output logic [MAX_LOG2-1:0] data_out_idx
`endif
);

  typedef enum logic {FILL, PAIR} state_t;

  state_t              state_q, state_d;
  logic [MAX_LOG2-1:0] cnt_q, cnt_d;
  logic [CFG_W-1:0]    cfg_q;
  logic [MAX_LOG2-1:0] last_cnt;
  logic                at_last;
  logic                wr_en;
  logic                pair_acc;
  logic                wrap;

  logic [DATA_W-1:0]   mem [2**MAX_LOG2];

  // Clamp the requested log2 length into 1..MAX_LOG2.
  function automatic logic [CFG_W-1:0] clamp_cfg(input logic [CFG_W-1:0] c);
    if (c < CFG_W'(1))             return CFG_W'(1);
    else if (c > CFG_W'(MAX_LOG2)) return CFG_W'(MAX_LOG2);
    else                           return c;
  endfunction

  // half_len-1 as a thermometer mask: bit i is set when i < log2(half_len).
  // This avoids a shifter and a subtract on the terminal-count path.
  for (genvar i = 0; i < MAX_LOG2; i++) begin : g_last
    assign last_cnt[i] = (cfg_q > CFG_W'(i));
  end

  assign at_last = (cnt_q == last_cnt);

  // Next-state logic. A cycle without a valid sample leaves everything as is.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_en    = 1'b0;
    pair_acc = 1'b0;
    wrap     = 1'b0;
    if (data_in_valid) begin
      cnt_d = at_last ? '0 : cnt_q + 1'b1;
      unique case (state_q)
        FILL: begin
          wr_en = 1'b1;
          if (at_last) state_d = PAIR;
        end
        PAIR: begin
          pair_acc = 1'b1;
          if (at_last) begin
            state_d = FILL;
            wrap    = 1'b1;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= FILL;
      cnt_q          <= '0;
      cfg_q          <= clamp_cfg(half_len_log2);
      data_out1      <= '0;
      data_out2      <= '0;
      data_out_valid <= 1'b0;
      data_out_last  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      if (wrap) cfg_q <= clamp_cfg(half_len_log2);
      data_out_valid <= pair_acc;
      data_out_last  <= pair_acc & at_last;
      // The pair registers hold their value through gaps.
      if (pair_acc) begin
        data_out1 <= mem[cnt_q];
        data_out2 <= data_in;
      end
    end
  end

`ifdef FFT_PAIR_BUF_IDX_EN
  always_ff @(posedge clk) begin
    if (rst)           data_out_idx <= '0;
    else if (pair_acc) data_out_idx <= cnt_q;
  end
`endif

  // RAM writes happen only in FILL and reads only in PAIR, so an address is
  // never read and written on the same edge, even across back-to-back frames.
  always_ff @(posedge clk) begin
    if (wr_en) mem[cnt_q] <= data_in;
  end

endmodule

// File: tb/tb_fft_pair_buffer.sv
module tb_fft_pair_buffer;

  localparam int DW = 64;
  localparam int ML = 3;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] half_len_log2;
  logic [DW-1:0] data_in;
  logic          data_in_valid;
  logic [DW-1:0] data_out1, data_out2;
  logic          data_out_valid, data_out_last;
`ifdef FFT_PAIR_BUF_IDX_EN
  logic [ML-1:0] data_out_idx;
`endif

  always #5 clk = ~clk;

  fft_pair_buffer #(.DATA_W(DW), .MAX_LOG2(ML), .CFG_W(CW)) dut (
    .clk(clk), .rst(rst), .half_len_log2(half_len_log2),
    .data_in(data_in), .data_in_valid(data_in_valid),
    .data_out1(data_out1), .data_out2(data_out2),
    .data_out_valid(data_out_valid), .data_out_last(data_out_last)
`ifdef FFT_PAIR_BUF_IDX_EN
    , .data_out_idx(data_out_idx)
`endif
  );

  int checks = 0;
  int failures = 0;
  int pairs_seen = 0;

  // Reference model: it collects each frame's samples and pairs them by
  // position. Expected outputs are for the cycle after the edge just applied.
  logic [DW-1:0] frame[$];
  int            hl;
  logic          exp_v, exp_l;
  logic [DW-1:0] exp_d1, exp_d2;
  int            exp_idx;

  function automatic int hl_of(input int c);
    if (c < 1) return 2;
    if (c > ML) return 1 << ML;
    return 1 << c;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit r, input bit v, input logic [DW-1:0] d, input int c);
    int n;
    if (r) begin
      frame.delete();
      hl = hl_of(c);
      exp_v = 0; exp_l = 0; exp_d1 = '0; exp_d2 = '0; exp_idx = 0;
    end else begin
      exp_v = 0;
      exp_l = 0;
      if (v) begin
        frame.push_back(d);
        n = frame.size();
        if (n > hl) begin
          exp_v   = 1;
          exp_idx = n - 1 - hl;
          exp_d1  = frame[n-1-hl];
          exp_d2  = d;
          exp_l   = (n == 2*hl);
          if (n == 2*hl) begin
            frame.delete();
            hl = hl_of(c);
          end
        end
      end
    end
  endtask

  // Drive one cycle, advance the model at the edge, and check at the falling edge.
  task automatic cyc(input bit r, input bit v, input logic [DW-1:0] d, input int c);
    rst = r; data_in_valid = v; data_in = d; half_len_log2 = CW'(c);
    @(posedge clk);
    model(r, v, d, c);
    @(negedge clk);
    chk("valid", DW'(data_out_valid), DW'(exp_v));
    chk("last",  DW'(data_out_last),  DW'(exp_l));
    chk("x1",    data_out1, exp_d1);
    chk("x2",    data_out2, exp_d2);
`ifdef FFT_PAIR_BUF_IDX_EN
    chk("idx",   DW'(data_out_idx), DW'(exp_idx));
`endif
    if (data_out_valid) pairs_seen++;
  endtask

  initial begin
    rst = 1; data_in_valid = 0; data_in = '0; half_len_log2 = 2;
    @(negedge clk);
    // Reset state
    cyc(1, 0, '0, 2);
    cyc(1, 0, '0, 2);

    // Contiguous frame 0..7, half_len=4
    pairs_seen = 0;
    for (int i = 0; i < 8; i++) cyc(0, 1, DW'(i), 2);
    cyc(0, 0, '0, 2);
    chk("pairs_frame0", DW'(pairs_seen), DW'(4));

    // Gapped frame
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, DW'(i), 2);
      cyc(0, 0, DW'(100 + i), 2);
    end

    // Back-to-back frames 0..15
    pairs_seen = 0;
    for (int i = 0; i < 16; i++) cyc(0, 1, DW'(i), 2);
    cyc(0, 0, '0, 2);
    chk("pairs_b2b", DW'(pairs_seen), DW'(8));

    // Reconfig 2->1 after sample 2 of frame 1
    for (int i = 0; i < 8; i++) cyc(0, 1, DW'(i), (i < 3) ? 2 : 1);
    pairs_seen = 0;
    for (int i = 8; i < 12; i++) cyc(0, 1, DW'(i), 1);
    cyc(0, 0, '0, 1);
    chk("pairs_reconfig", DW'(pairs_seen), DW'(2));

    // Clamp low (0 -> half_len 2), then clamp high (7 -> half_len 8)
    for (int i = 0; i < 4; i++) cyc(0, 1, DW'(50 + i), 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, DW'(60 + i), 7);
    pairs_seen = 0;
    for (int i = 0; i < 16; i++) cyc(0, 1, DW'(i), 7);
    cyc(0, 0, '0, 7);
    chk("pairs_clamp8", DW'(pairs_seen), DW'(8));

    // Reset mid-frame
    cyc(1, 0, '0, 2);
    for (int i = 0; i < 6; i++) cyc(0, 1, DW'(i), 2);
    cyc(1, 1, DW'(99), 2);
    pairs_seen = 0;
    for (int i = 20; i < 28; i++) cyc(0, 1, DW'(i), 2);
    cyc(0, 0, '0, 2);
    chk("pairs_after_rst", DW'(pairs_seen), DW'(4));

    // Randomized traffic: gaps, random data, config churn, occasional reset
    begin
      int c = 2;
      for (int k = 0; k < 1500; k++) begin
        if ($urandom_range(0, 15) == 0) c = $urandom_range(0, 7);
        cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
            {$urandom, $urandom}, c);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_pair_buffer.md
Name: fft_pair_buffer

Overview:
- Parametrised radix-2 SDF pairing buffer for one FFT stage.
- Buffers the first half-frame of streamed complex samples in internal RAM, then emits each stored sample (x1) alongside the matching second-half input sample (x2).
- Half-frame length is selectable at run time up to a compile-time maximum.
- Replaces fixed-size vendor-FIFO pairing with a counter-driven design that tolerates input gaps and flags the last pair of each frame.

Parameters:
- DATA_W, 64, width of one complex sample (real and imaginary float concatenated).
- MAX_LOG2, 11, log2 of the maximum half-frame length; the RAM holds 2^MAX_LOG2 entries.
- CFG_W, 4, width of the half_len_log2 port; must be able to represent MAX_LOG2.

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- half_len_log2  input  CFG_W  requested log2 of the half-frame length.
- data_in  input  DATA_W  input sample.
- data_in_valid  input  1  data_in is valid this cycle.
- data_out1  output  DATA_W  x1: buffered first-half sample.
- data_out2  output  DATA_W  x2: second-half sample paired with x1.
- data_out_valid  output  1  data_out1/data_out2 form a valid pair.
- data_out_last  output  1  marks the last pair of a frame; only high together with data_out_valid.

Behaviour:
- Reset (synchronous, active-high):
  - state=FILL, cnt=0, half_len latched from clamped half_len_log2.
  - data_out1=0, data_out2=0, data_out_valid=0, data_out_last=0.
  - RAM contents are don't-care.
- Reset mid-frame: the partial frame is discarded; the next valid sample is sample 0 of a new frame.
- Clamp: half_len_log2<1 -> 1; >MAX_LOG2 -> MAX_LOG2. half_len = 2^clamped value.
- Config latching: only at reset and on the FILL->PAIR->FILL wrap, i.e. the cycle the last pair is accepted. Changes at any other time are ignored until the next frame boundary.
- Cycles with data_in_valid=0 do not change state, cnt or RAM. data_out_valid=0 on the next cycle. data_out1/data_out2 hold their last values.
- FILL state, on a valid sample:
  - Write RAM[cnt]=data_in; cnt++.
  - If cnt==half_len-1: go to PAIR, cnt=0.
  - No output is produced in FILL.
- PAIR state, on a valid sample:
  - Read RAM[cnt] (synchronous read); register data_in as x2; cnt++.
  - If cnt==half_len-1: go to FILL, cnt=0, re-latch config.
- Output timing: 1-cycle latency from the accepting edge.
  - On the following cycle: data_out1=RAM[cnt], data_out2=data_in, data_out_valid=1.
  - data_out_last=1 for the pair from cnt==half_len-1.
- Back-to-back frames: the FILL sample that follows the last PAIR sample is accepted with no bubble. Reading RAM[k] and a later write to RAM[k] never occur in the same cycle, so no read/write collision is possible.
- Counter width is MAX_LOG2; the terminal compare uses the latched half_len, never the raw port.
- No backpressure: the consumer must accept every pair. No overflow is possible by construction.

Optional Feature:
- Macro: FFT_PAIR_BUF_IDX_EN.
- Defined:
  - Adds output port data_out_idx (MAX_LOG2 bits), the pair index 0..half_len-1 of the current pair, valid with data_out_valid.
  - Intended as the twiddle ROM address for the downstream butterfly.
  - Reset value 0; holds its value when data_out_valid=0.
- Undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
All scenarios use MAX_LOG2=3.
- Contiguous frame: half_len_log2=2, rst released, data_in=0..7 valid on cycles 0..7 -> pairs (0,4),(1,5),(2,6),(3,7) with data_out_valid high on cycles 5..8, data_out_last high on cycle 8 only; idx=0..3 when FFT_PAIR_BUF_IDX_EN is defined.
- Gapped input: same frame with data_in_valid low every other cycle -> same four pairs in order; data_out_valid is high only one cycle after each accepted second-half sample, never during gaps.
- Back-to-back frames: 16 contiguous samples 0..15 -> pairs (0,4)..(3,7) then (8,12)..(11,15) with no missing or extra valid cycle; data_out_last high after 7 and after 15.
- Reconfig at boundary: half_len_log2 changed 2->1 after sample 2 of frame 1 -> frame 1 still uses half_len=4; frame 2 with samples 8..11 gives pairs (8,10),(9,11).
- Clamp: half_len_log2=0 -> half_len=2; half_len_log2=7 -> half_len=8, and 16 samples 0..15 give pairs (0,8)..(7,15).
- Reset mid-frame: rst high for 1 cycle after samples 0..5 of a half_len=4 frame, then samples 20..27 -> all outputs 0 the cycle after reset; pairs (20,24)..(23,27) only, no stale data.
